// File: rtl/deadlock_dataflow_monitor_if.sv
// Signal bundle between a dataflow region and its deadlock monitor.
// The master side drives the status inputs. The slave side is the monitor, which returns the deadlock flag and statistics.
interface deadlock_dataflow_monitor_if #(
  parameter int NUM_PROC = 4,
  parameter int NUM_AXIS = 12,
  parameter int CNT_W    = 16
);
  logic                clear;
  logic [NUM_AXIS-1:0] axis_block_sigs;
  logic [NUM_PROC-1:0] inst_idle_sigs;
  logic [NUM_PROC-1:0] inst_block_sigs;
  logic [NUM_PROC-1:0] child_block;
  logic                block;
  logic [NUM_PROC-1:0] block_proc_vec;
  logic [CNT_W-1:0]    deadlock_count;

  modport master (
    output clear, axis_block_sigs, inst_idle_sigs, inst_block_sigs, child_block,
    input  block, block_proc_vec, deadlock_count
  );

  modport slave (
    input  clear, axis_block_sigs, inst_idle_sigs, inst_block_sigs, child_block,
    output block, block_proc_vec, deadlock_count
  );
endinterface

// File: rtl/deadlock_dataflow_monitor.sv
// Deadlock monitor for one dataflow region. It flags a region-wide stop condition that persists for THRESHOLD cycles.
// It also snapshots the stream-blocked processes and counts deadlock entries.
module deadlock_dataflow_monitor #(
  parameter int                            NUM_PROC   = 4,
  parameter int                            NUM_AXIS   = 12,
  parameter logic [NUM_PROC*NUM_AXIS-1:0]  AXIS_MAP   = '0,
  parameter logic [NUM_PROC-1:0]           CHILD_MASK = '0,
  parameter int                            THRESHOLD  = 1,
  parameter bit                            STICKY     = 1'b0,
  parameter int                            CNT_W      = 16
) (
  input logic                        clock,
  input logic                        reset,
  deadlock_dataflow_monitor_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARMED, BLOCKED} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TH_C    = CNT_W'(THRESHOLD);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0]    count_q;
  logic [NUM_PROC-1:0] vec_q;
  logic [NUM_PROC-1:0] axis_blk;
  logic [NUM_PROC-1:0] stop;
  logic                cond;
  logic                enter_blocked;

  // Nested regions only count as stream-blocked once their own monitor agrees.
  always_comb begin
    axis_blk = '0;
    for (int p = 0; p < NUM_PROC; p++) begin
      axis_blk[p] = |(AXIS_MAP[p*NUM_AXIS +: NUM_AXIS] & bus.axis_block_sigs);
      if (CHILD_MASK[p]) axis_blk[p] = axis_blk[p] & bus.child_block[p];
    end
  end

  assign stop = bus.inst_idle_sigs | bus.inst_block_sigs | axis_blk;
  assign cond = (|axis_blk) & (&stop);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    if (bus.clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cond) begin
            cnt_d   = CNT_W'(1);
            state_d = (THRESHOLD == 1) ? BLOCKED : ARMED;
          end
        end
        ARMED: begin
          if (cond) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= TH_C) state_d = BLOCKED;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        BLOCKED: begin
          if (cond) begin
            cnt_d = cnt_inc;
          end else if (!STICKY) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign enter_blocked = (state_d == BLOCKED) && (state_q != BLOCKED);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (enter_blocked) begin
        vec_q <= axis_blk;
        if (count_q != CNT_MAX) count_q <= count_q + 1'b1;
      end
    end
  end

  assign bus.block          = (state_q == BLOCKED);
  assign bus.block_proc_vec = vec_q;
  assign bus.deadlock_count = count_q;

endmodule
